sgr_param_sequencer: RTL and testbench
======================================

// Module: sgr_param_sequencer
// PURPOSE
//  Buffers the numeric parameters of one CSI ... 'm' (SGR) escape sequence from the escape parser.
//  On sequence end, replays them to the graphics attribute controller as a timed command stream:
//  INIT_PN, then EMIT_PN per parameter, then SGR carrying the last one; an empty list sends SGR0 only.
//  Sole driver of the graphics controller's commandReady/commandType/Pns inputs.
//  Guarantees the idle spacing the controller needs to commit attributes.
// PARAMETERS
//  DEPTH       16  max parameters buffered per sequence (>=1)
//  GAP_CYCLES   1  idle cycles after every issued command (>=1)
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, asynchronous, active-high
//  pn_valid    in   1   parameter strobe from parser
//  pn_data     in   8   parameter value (already saturated to 0..255 by parser)
//  pn_ready    out  1   parameter accepted when pn_valid & pn_ready
//  seq_end     in   1   1-cycle pulse: final byte 'm' received
//  seq_abort   in   1   1-cycle pulse: sequence cancelled (CAN/SUB/ESC)
//  cmd_ready   out  1   1-cycle command strobe to graphics controller
//  cmd_type    out  CommandsType  INIT_PN / EMIT_PN / SGR / SGR0
//  cmd_pn      out  8   parameter value for cmd_type
//  busy        out  1   high from seq_end acceptance until return to COLLECT
//  overflow    out  1   1-cycle pulse when a parameter beyond DEPTH arrives
// BEHAVIOUR
//  Reset: state=COLLECT, count=0, pn_ready=1, cmd_ready=0, cmd_type=INIT_PN, cmd_pn=0, busy=0, overflow=0.
//  FSM: COLLECT -> (seq_end) ISSUE <-> GAP -> TAIL -> COLLECT.
//  COLLECT: pn_ready=1 always. pn_valid with count<DEPTH writes buf[count], count++.
//   pn_valid with count==DEPTH: value dropped, overflow pulses next cycle.
//   pn_valid and seq_end same cycle: parameter stored first, then included in the replay.
//   seq_abort: count<=0, stay in COLLECT; seq_abort beats seq_end in the same cycle.
//  seq_end accepted at edge T: busy=1 from T+1; first cmd_ready at T+1.
//  Command list, n=count: n==0 -> {SGR0, pn 0}.
//   n>=1 -> {INIT_PN, pn 0}, {EMIT_PN, buf[0]}..{EMIT_PN, buf[n-2]}, {SGR, buf[n-1]}.
//  ISSUE: cmd_ready=1 for exactly one cycle. Then GAP for GAP_CYCLES cycles with cmd_ready=0.
//   Command k's strobe is at T+1+k*(GAP_CYCLES+1).
//  After the final command's GAP: one TAIL cycle lets the controller commit, then COLLECT.
//   busy drops when COLLECT is entered. count is cleared on COLLECT entry.
//  Outside COLLECT: pn_ready=0 and seq_end/seq_abort are ignored; replay is atomic.
//  cmd_type/cmd_pn hold their last value while cmd_ready=0.
//  Read index width $clog2(DEPTH). count width $clog2(DEPTH+1); neither wraps.
//  Reset asserted mid-replay: all state cleared immediately, no further strobes.
// CONFIGURATION
//  SGR_OVERFLOW_DROP_EN defined: overflow during a sequence sets a sticky flag.
//   At seq_end with the flag set, nothing is issued; the block goes straight to TAIL with busy=1
//   for 1 cycle, then clears count and the flag.
//  Not defined: overflow truncates; the first DEPTH parameters replay normally.
//  The overflow pulse is identical in both builds.
// STRUCTURE
//  Shared package: CommandsType enum (INIT_PN, EMIT_PN, SGR, SGR0), SGR_SEQ_DEPTH default constant.
//  Sub-module sgr_param_buffer: DEPTH x 8 register file.
//   Synchronous write (wr_en, wr_addr, wr_data), combinational read (rd_addr).
//   Holds no count; no reset on storage.
//  The FSM, counters and gap timer stay in sgr_param_sequencer.
// TESTING
//  Params 1,31,4 then seq_end at T, GAP=1 -> INIT_PN/0 @T+1, EMIT_PN/1 @T+3, EMIT_PN/31 @T+5,
//   SGR/4 @T+7; busy low by T+10.
//  seq_end with no params -> single SGR0/0 strobe at T+1; no INIT_PN.
//  Params 38,5,196 with pn_valid(196) and seq_end in the same cycle
//   -> INIT_PN, EMIT_PN 38, EMIT_PN 5, SGR 196.
//  DEPTH=4, send 6 params, seq_end -> 2 overflow pulses.
//   Without macro: SGR carries the 4th param. With macro: zero cmd_ready strobes.
//  Params 7,1 then seq_abort, then param 0 and seq_end -> INIT_PN, SGR/0 only.
//   seq_abort together with seq_end -> no strobes.
//  rst asserted between 2nd and 3rd strobe -> cmd_ready 0 thereafter, busy=0, pn_ready=1.
//   A new sequence replays correctly.

Source files
------------

// File: rtl/sgr_param_sequencer_pkg.sv
// Shared types and constants for the SGR parameter sequencer and its parameter buffer.
package sgr_param_sequencer_pkg;

    typedef enum logic [1:0] {
        INIT_PN = 2'd0,
        EMIT_PN = 2'd1,
        SGR     = 2'd2,
        SGR0    = 2'd3
    } CommandsType;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_GAP     = 2'd2,
        ST_TAIL    = 2'd3
    } seq_state_t;

    localparam int SGR_SEQ_DEPTH = 16;

    // A single-entry buffer still needs a one-bit address.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sgr_param_sequencer_buffer.sv
// sgr_param_buffer: DEPTH x 8 parameter register file, synchronous write, combinational read.
module sgr_param_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    // Storage is never reset: only entries below the sequencer's count are ever read.
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sgr_param_sequencer.sv
// Collects SGR parameters and replays them as a spaced INIT_PN/EMIT_PN/SGR (or SGR0) command stream.
// Optional build macro SGR_OVERFLOW_DROP_EN: a sequence that overflowed is discarded instead of truncated.
module sgr_param_sequencer
    import sgr_param_sequencer_pkg::*;
#(
    parameter int DEPTH      = SGR_SEQ_DEPTH,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pn_valid,
    input  logic [7:0]  pn_data,
    output logic        pn_ready,
    input  logic        seq_end,
    input  logic        seq_abort,
    output logic        cmd_ready,
    output CommandsType cmd_type,
    output logic [7:0]  cmd_pn,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = idx_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    seq_state_t  state_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] cmd_idx_q;
    logic [GW-1:0] gap_q;
    logic        cmd_ready_q;
    CommandsType cmd_type_q;
    logic [7:0]  cmd_pn_q;
    logic        busy_q;
    logic        overflow_q;
    logic        pn_ready_q;

    logic          in_collect;
    logic          has_room;
    logic          wr_en;
    logic          ovf_now;
    logic          skip_replay;
    logic [CW-1:0] count_d;
    logic [CW-1:0] cmd_idx_d;
    logic [7:0]    rd_data;

    assign in_collect = (state_q == ST_COLLECT);
    assign has_room   = (count_q != CW'(DEPTH));
    assign wr_en      = in_collect && pn_valid && has_room;
    assign ovf_now    = in_collect && pn_valid && !has_room;
    // A parameter arriving with seq_end is counted before the replay starts.
    assign count_d    = count_q + CW'(wr_en);
    assign cmd_idx_d  = cmd_idx_q + CW'(1);

`ifdef SGR_OVERFLOW_DROP_EN
    logic drop_q;
    assign skip_replay = drop_q || ovf_now;
`else
    assign skip_replay = 1'b0;
`endif

    sgr_param_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (AW'(count_q)),
        .wr_data (pn_data),
        .rd_addr (AW'(cmd_idx_q)),
        .rd_data (rd_data)
    );

`ifdef SGR_OVERFLOW_DROP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else if (in_collect) begin
            if (seq_abort || seq_end) begin
                drop_q <= 1'b0;
            end else if (ovf_now) begin
                drop_q <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            count_q     <= '0;
            cmd_idx_q   <= '0;
            gap_q       <= '0;
            cmd_ready_q <= 1'b0;
            cmd_type_q  <= INIT_PN;
            cmd_pn_q    <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            pn_ready_q  <= 1'b1;
        end else begin
            cmd_ready_q <= 1'b0;
            overflow_q  <= ovf_now;
            case (state_q)
                ST_COLLECT: begin
                    if (seq_abort) begin
                        count_q <= '0;
                    end else if (seq_end) begin
                        count_q    <= count_d;
                        cmd_idx_q  <= '0;
                        busy_q     <= 1'b1;
                        pn_ready_q <= 1'b0;
                        if (skip_replay) begin
                            state_q <= ST_TAIL;
                        end else begin
                            state_q     <= ST_ISSUE;
                            cmd_ready_q <= 1'b1;
                            cmd_type_q  <= (count_d == '0) ? SGR0 : INIT_PN;
                            cmd_pn_q    <= '0;
                        end
                    end else begin
                        count_q <= count_d;
                    end
                end
                ST_ISSUE: begin
                    gap_q   <= GW'(GAP_CYCLES - 1);
                    state_q <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - GW'(1);
                    end else if (cmd_idx_q == count_q) begin
                        // The SGR/SGR0 just went out; give the controller its commit cycle.
                        state_q <= ST_TAIL;
                    end else begin
                        cmd_idx_q   <= cmd_idx_d;
                        cmd_ready_q <= 1'b1;
                        cmd_type_q  <= (cmd_idx_d == count_q) ? SGR : EMIT_PN;
                        cmd_pn_q    <= rd_data;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_TAIL: begin
                    state_q    <= ST_COLLECT;
                    busy_q     <= 1'b0;
                    pn_ready_q <= 1'b1;
                    count_q    <= '0;
                    cmd_idx_q  <= '0;
                end
                default: begin
                    state_q <= ST_COLLECT;
                end
            endcase
        end
    end

    assign pn_ready  = pn_ready_q;
    assign cmd_ready = cmd_ready_q;
    assign cmd_type  = cmd_type_q;
    assign cmd_pn    = cmd_pn_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sgr_param_sequencer.sv
// Directed bench for sgr_param_sequencer: command order, strobe spacing, overflow, abort and reset.
module tb_sgr_param_sequencer;
    import sgr_param_sequencer_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP   = 1;
    localparam int STEP  = GAP + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pn_valid = 1'b0;
    logic [7:0]  pn_data = 8'd0;
    logic        pn_ready;
    logic        seq_end = 1'b0;
    logic        seq_abort = 1'b0;
    logic        cmd_ready;
    CommandsType cmd_type;
    logic [7:0]  cmd_pn;
    logic        busy;
    logic        overflow;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int accept_cyc = 0;
    int ovf_cnt = 0;
    int st_cyc[$];
    int st_type[$];
    int st_pn[$];
    int exp_type[$];
    int exp_pn[$];

    sgr_param_sequencer #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pn_valid  (pn_valid),
        .pn_data   (pn_data),
        .pn_ready  (pn_ready),
        .seq_end   (seq_end),
        .seq_abort (seq_abort),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_pn    (cmd_pn),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_ready) begin
            st_cyc.push_back(cyc);
            st_type.push_back(int'(cmd_type));
            st_pn.push_back(int'(cmd_pn));
            $display("cmd  cyc=%0d type=%0d pn=%0d", cyc, int'(cmd_type), int'(cmd_pn));
        end
        if (overflow) ovf_cnt <= ovf_cnt + 1;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_pn(input logic [7:0] v);
        pn_valid = 1'b1;
        pn_data  = v;
        @(posedge clk); #1;
        pn_valid = 1'b0;
    endtask

    task automatic end_seq(input bit with_pn, input logic [7:0] v, input bit abort);
        pn_valid  = with_pn;
        pn_data   = v;
        seq_end   = 1'b1;
        seq_abort = abort;
        @(posedge clk); #1;
        accept_cyc = cyc;
        pn_valid  = 1'b0;
        seq_end   = 1'b0;
        seq_abort = 1'b0;
    endtask

    task automatic abort_seq();
        seq_abort = 1'b1;
        @(posedge clk); #1;
        seq_abort = 1'b0;
    endtask

    task automatic wait_idle(output int drop_off);
        drop_off = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                drop_off = cyc - accept_cyc;
                break;
            end
        end
        check_val("idle_reached", int'(drop_off >= 0), 1);
        @(posedge clk); #1;
    endtask

    task automatic expect_cmd(input CommandsType t, input int p);
        exp_type.push_back(int'(t));
        exp_pn.push_back(p);
    endtask

    task automatic check_stream(input string tag, input int base);
        check_val({tag, "_count"}, st_cyc.size() - base, exp_type.size());
        for (int i = 0; i < exp_type.size(); i++) begin
            if (base + i < st_cyc.size()) begin
                check_val({tag, "_type"}, st_type[base + i], exp_type[i]);
                check_val({tag, "_pn"}, st_pn[base + i], exp_pn[i]);
                check_val({tag, "_offset"}, st_cyc[base + i] - accept_cyc, i * STEP);
            end
        end
        $display("seq  %s: %0d strobes", tag, st_cyc.size() - base);
        exp_type.delete();
        exp_pn.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int off;
        int ovf_base;
        int seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_pn_ready", int'(pn_ready), 1);
        check_val("rst_cmd_ready", int'(cmd_ready), 0);
        check_val("rst_cmd_type", int'(cmd_type), int'(INIT_PN));
        check_val("rst_cmd_pn", int'(cmd_pn), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_overflow", int'(overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1, 31, 4: full list with spacing and busy timing
        base = st_cyc.size();
        send_pn(8'd1); send_pn(8'd31); send_pn(8'd4);
        end_seq(1'b0, 8'd0, 1'b0);
        @(negedge clk);
        check_val("t1_busy_high", int'(busy), 1);
        check_val("t1_pn_ready_low", int'(pn_ready), 0);
        expect_cmd(INIT_PN, 0); expect_cmd(EMIT_PN, 1); expect_cmd(EMIT_PN, 31); expect_cmd(SGR, 4);
        wait_idle(off);
        check_val("t1_busy_drop", off, 9);
        check_val("t1_pn_ready_back", int'(pn_ready), 1);
        check_stream("t1", base);

        // 38, 5, then 196 together with seq_end
        base = st_cyc.size();
        send_pn(8'd38); send_pn(8'd5);
        end_seq(1'b1, 8'd196, 1'b0);
        expect_cmd(INIT_PN, 0); expect_cmd(EMIT_PN, 38); expect_cmd(EMIT_PN, 5); expect_cmd(SGR, 196);
        wait_idle(off);
        check_stream("t2", base);

        // six parameters into a four-deep buffer
        base = st_cyc.size();
        ovf_base = ovf_cnt;
        for (int i = 0; i < 6; i++) send_pn(8'(10 + i));
        end_seq(1'b0, 8'd0, 1'b0);
`ifndef SGR_OVERFLOW_DROP_EN
        expect_cmd(INIT_PN, 0); expect_cmd(EMIT_PN, 10); expect_cmd(EMIT_PN, 11);
        expect_cmd(EMIT_PN, 12); expect_cmd(SGR, 13);
`endif
        wait_idle(off);
        check_val("t3_overflow_pulses", ovf_cnt - ovf_base, 2);
        check_stream("t3", base);
        check_val("t3_hold_type", int'(cmd_type), int'(SGR));
`ifdef SGR_OVERFLOW_DROP_EN
        check_val("t3_hold_pn", int'(cmd_pn), 196);
`else
        check_val("t3_hold_pn", int'(cmd_pn), 13);
`endif

        // empty list
        base = st_cyc.size();
        end_seq(1'b0, 8'd0, 1'b0);
        expect_cmd(SGR0, 0);
        wait_idle(off);
        check_stream("t4", base);

        // 7, 1, abort, then 0 and seq_end
        base = st_cyc.size();
        send_pn(8'd7); send_pn(8'd1);
        abort_seq();
        send_pn(8'd0);
        end_seq(1'b0, 8'd0, 1'b0);
        expect_cmd(INIT_PN, 0); expect_cmd(SGR, 0);
        wait_idle(off);
        check_stream("t5", base);

        // abort together with seq_end, then an empty list must still be empty
        base = st_cyc.size();
        send_pn(8'd9);
        end_seq(1'b0, 8'd0, 1'b1);
        wait_idle(off);
        check_stream("t6_abort", base);
        base = st_cyc.size();
        end_seq(1'b0, 8'd0, 1'b0);
        expect_cmd(SGR0, 0);
        wait_idle(off);
        check_stream("t6_after", base);

        // reset between second and third strobe
        base = st_cyc.size();
        send_pn(8'd2); send_pn(8'd3); send_pn(8'd4);
        end_seq(1'b0, 8'd0, 1'b0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) seen++;
            if (seen == 2) break;
        end
        check_val("t7_two_strobes_seen", seen, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_val("t7_rst_cmd_ready", int'(cmd_ready), 0);
        check_val("t7_rst_busy", int'(busy), 0);
        check_val("t7_rst_pn_ready", int'(pn_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        expect_cmd(INIT_PN, 0); expect_cmd(EMIT_PN, 2);
        check_stream("t7_cut", base);
        @(posedge clk); #1;
        base = st_cyc.size();
        send_pn(8'd8); send_pn(8'd9);
        end_seq(1'b0, 8'd0, 1'b0);
        expect_cmd(INIT_PN, 0); expect_cmd(EMIT_PN, 8); expect_cmd(SGR, 9);
        wait_idle(off);
        check_stream("t7_new", base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
